// File: rtl/alu_4_bit_ctrl.sv
// alu_4_bit_ctrl: command-side controller for the 4-bit combinational ALU.
//
// Accepts an operation over a valid/ready command port and drives operands and
// opcode onto the ALU. After SETTLE_CYCLES edges it samples the ALU result into
// res_data and an accumulator, then offers the result on a valid/ready port.
//
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready - command handshake; cmd_ready is high only in IDLE
//   cmd_opcode      - 0=add, 1=and, 2=or, 3=xor
//   cmd_a, cmd_b    - operands; cmd_use_acc substitutes acc for cmd_a
//   alu_a/b/opcode  - registered drive to the ALU, stable between acceptances
//   alu_op          - 5-bit ALU result, sampled only on the capture edge
//   res_valid/ready - result handshake
//   res_data        - captured 5-bit result
//   acc             - low 4 bits of the last captured result
//   op_count        - completed-operation counter, wraps
module alu_4_bit_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_opcode,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   input  logic             cmd_use_acc,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [1:0]       alu_opcode,
   input  logic [4:0]       alu_op,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [4:0]       res_data,
   output logic [3:0]       acc,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

   // Counter is loaded with SETTLE_CYCLES-1 so capture lands SETTLE_CYCLES edges
   // after the accept edge.
   localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES - 1);

   state_e           state_q;
   logic [3:0]       settle_q;
   logic [3:0]       alu_a_q;
   logic [3:0]       alu_b_q;
   logic [1:0]       alu_opcode_q;
   logic             res_valid_q;
   logic [4:0]       res_data_q;
   logic [3:0]       acc_q;
   logic [CNT_W-1:0] op_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         settle_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_opcode_q <= '0;
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         acc_q        <= '0;
         op_count_q   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  // acc_q here is the previous result, before any new capture.
                  alu_a_q      <= cmd_use_acc ? acc_q : cmd_a;
                  alu_b_q      <= cmd_b;
                  alu_opcode_q <= cmd_opcode;
                  settle_q     <= SettleInit;
                  state_q      <= StDrive;
               end
            end
            StDrive: begin
               if (settle_q == 4'd0) begin
                  res_data_q  <= alu_op;
                  acc_q       <= alu_op[3:0];
                  res_valid_q <= 1'b1;
                  state_q     <= StHold;
               end else begin
                  settle_q <= settle_q - 4'd1;
               end
            end
            StHold: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  op_count_q  <= op_count_q + CNT_W'(1);
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cmd_ready  = (state_q == StIdle);
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_opcode_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign acc        = acc_q;
   assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_4_bit_ctrl.sv
// Directed bench for alu_4_bit_ctrl. One instance (SETTLE_CYCLES=1) is attached
// to a behavioural ALU; a second (SETTLE_CYCLES=3) has its alu_op driven
// directly by the stimulus to probe the capture edge.
module tb_alu_4_bit_ctrl;

   logic clk    = 1'b0;
   logic clk_en = 1'b1;
   logic rst_n  = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   // Instance 1 (SETTLE_CYCLES = 1)
   logic       cmd_valid, cmd_ready, cmd_use_acc, res_valid, res_ready;
   logic [1:0] cmd_opcode, alu_opcode;
   logic [3:0] cmd_a, cmd_b, alu_a, alu_b, acc;
   logic [4:0] alu_op, res_data;
   logic [7:0] op_count;

   // Instance 3 (SETTLE_CYCLES = 3)
   logic       cmd_valid3, cmd_ready3, cmd_use_acc3, res_valid3, res_ready3;
   logic [1:0] cmd_opcode3, alu_opcode3;
   logic [3:0] cmd_a3, cmd_b3, alu_a3, alu_b3, acc3;
   logic [4:0] alu_op3, res_data3;
   logic [7:0] op_count3;

   alu_4_bit_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_op(alu_op),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .acc(acc), .op_count(op_count)
   );

   alu_4_bit_ctrl #(.SETTLE_CYCLES(3), .CNT_W(8)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_opcode(cmd_opcode3),
      .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_use_acc(cmd_use_acc3),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_opcode3), .alu_op(alu_op3),
      .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
      .acc(acc3), .op_count(op_count3)
   );

   // Gated clock so reset can be exercised with the clock stopped low.
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
      case (op)
         2'd0:    alu_f = {1'b0, a} + {1'b0, b};
         2'd1:    alu_f = {1'b0, a & b};
         2'd2:    alu_f = {1'b0, a | b};
         default: alu_f = {1'b0, a ^ b};
      endcase
   endfunction

   always_comb alu_op = alu_f(alu_a, alu_b, alu_opcode);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd1(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                       input logic use_acc);
      cmd_valid   = 1'b1;
      cmd_a       = a;
      cmd_b       = b;
      cmd_opcode  = op;
      cmd_use_acc = use_acc;
   endtask

   initial begin
      cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_opcode = 0; cmd_use_acc = 0; res_ready = 0;
      cmd_valid3 = 0; cmd_a3 = 0; cmd_b3 = 0; cmd_opcode3 = 0; cmd_use_acc3 = 0;
      res_ready3 = 0; alu_op3 = 0;

      #1 rst_n = 1'b0;
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      #10 rst_n = 1'b1;

      // Add with carry: F + 1 = 0x10
      res_ready = 1'b1;
      cmd1(4'hF, 4'h1, 2'd0, 1'b0);
      tick();
      cmd_valid = 1'b0;
      check("add_alu_a", 32'(alu_a), 32'hF);
      check("add_alu_b", 32'(alu_b), 32'h1);
      check("add_busy", 32'(cmd_ready), 32'd0);
      check("add_noval_yet", 32'(res_valid), 32'd0);
      tick();
      check("add_res_valid", 32'(res_valid), 32'd1);
      check("add_res_data", 32'(res_data), 32'h10);
      check("add_acc", 32'(acc), 32'h0);
      tick();
      check("add_op_count", 32'(op_count), 32'd1);
      check("add_done", 32'(res_valid), 32'd0);
      check("add_idle", 32'(cmd_ready), 32'd1);

      // Accumulator chain: 3+4=7, then acc ^ 5 = 2 (cmd_a ignored)
      cmd1(4'h3, 4'h4, 2'd0, 1'b0);
      tick();
      cmd_valid = 1'b0;
      tick();
      check("chain1_res", 32'(res_data), 32'h07);
      check("chain1_acc", 32'(acc), 32'h7);
      tick();
      cmd1(4'hA, 4'h5, 2'd3, 1'b1);
      tick();
      cmd_valid = 1'b0;
      check("chain2_alu_a", 32'(alu_a), 32'h7);
      check("chain2_opc", 32'(alu_opcode), 32'd3);
      tick();
      check("chain2_res", 32'(res_data), 32'h02);
      check("chain2_acc", 32'(acc), 32'h2);
      tick();
      check("chain_op_count", 32'(op_count), 32'd3);

      // Backpressure: 5 & C = 4, held for 5 cycles against a competing command
      res_ready = 1'b0;
      cmd1(4'h5, 4'hC, 2'd1, 1'b0);
      tick();
      cmd_valid = 1'b0;
      tick();
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_data", 32'(res_data), 32'h04);
      cmd1(4'h9, 4'h6, 2'd2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_valid", 32'(res_valid), 32'd1);
         check("bp_hold_data", 32'(res_data), 32'h04);
         check("bp_hold_busy", 32'(cmd_ready), 32'd0);
         check("bp_hold_alu_a", 32'(alu_a), 32'h5);
      end
      res_ready = 1'b1;
      tick();
      check("bp_op_count", 32'(op_count), 32'd4);
      check("bp_released", 32'(res_valid), 32'd0);
      check("bp_no_bypass", 32'(alu_a), 32'h5);
      tick();
      cmd_valid = 1'b0;
      check("bp_pending_a", 32'(alu_a), 32'h9);
      check("bp_pending_opc", 32'(alu_opcode), 32'd2);
      tick();
      check("bp_pending_res", 32'(res_data), 32'h0F);
      tick();
      check("bp_op_count2", 32'(op_count), 32'd5);

      // Asynchronous reset with the clock stopped
      @(negedge clk);
      clk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_alu_a", 32'(alu_a), 32'h0);
      check("arst_alu_b", 32'(alu_b), 32'h0);
      check("arst_opc", 32'(alu_opcode), 32'h0);
      check("arst_res_data", 32'(res_data), 32'h0);
      check("arst_acc", 32'(acc), 32'h0);
      check("arst_op_count", 32'(op_count), 32'h0);
      check("arst_res_valid", 32'(res_valid), 32'd0);
      check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
      #5 rst_n = 1'b1;
      #1;
      check("arst_rel_ready", 32'(cmd_ready), 32'd1);
      clk_en = 1'b1;

      // Settle timing on the 3-cycle instance: 2 | 4 = 6, garbage before capture
      res_ready3  = 1'b1;
      cmd_valid3  = 1'b1;
      cmd_a3      = 4'h2;
      cmd_b3      = 4'h4;
      cmd_opcode3 = 2'd2;
      tick();
      cmd_valid3 = 1'b0;
      alu_op3    = 5'h1F;
      check("st_alu_a", 32'(alu_a3), 32'h2);
      check("st_v0", 32'(res_valid3), 32'd0);
      tick();
      check("st_v1", 32'(res_valid3), 32'd0);
      tick();
      check("st_v2", 32'(res_valid3), 32'd0);
      alu_op3 = 5'h06;
      tick();
      check("st_v3", 32'(res_valid3), 32'd1);
      check("st_res", 32'(res_data3), 32'h06);
      check("st_acc", 32'(acc3), 32'h6);
      tick();
      check("st_op_count", 32'(op_count3), 32'd1);

      // Reset during DRIVE aborts the command
      cmd_valid3  = 1'b1;
      cmd_a3      = 4'h1;
      cmd_b3      = 4'h1;
      cmd_opcode3 = 2'd0;
      tick();
      cmd_valid3 = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_acc", 32'(acc3), 32'h0);
      check("abort_op_count", 32'(op_count3), 32'd0);
      check("abort_ready", 32'(cmd_ready3), 32'd1);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("abort_no_valid", 32'(res_valid3), 32'd0);
      end

      // Counter wrap: back-to-back commands, 3 edges per completion
      cmd1(4'h1, 4'h1, 2'd0, 1'b0);
      res_ready = 1'b1;
      repeat (255 * 3) tick();
      check("wrap_255", 32'(op_count), 32'd255);
      repeat (3) tick();
      check("wrap_0", 32'(op_count), 32'd0);
      cmd_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
